// File: rtl/sd_wb_bridge.sv
// sd_wb_bridge: Wishbone classic master between the SD register
// mapper and the SD controller slave port; writes win over polling.
module sd_wb_bridge #(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sd_addr,
  input  logic        sd_we,
  input  logic [31:0] sd_out,
  output logic [31:0] sd_in,
  output logic        busy,
  output logic        err,
  output logic        ovr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    GAP
  } state_t;

  localparam logic [7:0] TMO  = 8'(TIMEOUT);
  localparam logic [7:0] GAPV = 8'(POLL_GAP);

  state_t      state_q;
  logic        pend_v_q;
  logic [1:0]  pend_adr_q;
  logic [31:0] pend_dat_q;
  logic [7:0]  gap_q;
  logic [7:0]  to_q;
  logic [7:0]  to_d;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic [31:0] sd_in_q;
  logic        err_q;
  logic        ovr_q;
  logic        consume;

  assign consume = (state_q == IDLE) && pend_v_q;
  assign to_d    = to_q + 8'd1;

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = dat_q;
  assign sd_in    = sd_in_q;
  assign err      = err_q;
  assign ovr      = ovr_q;
  assign busy     = (state_q != IDLE) || pend_v_q;

  // pending write buffer; a strobe landing on an unissued write overwrites it
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q   <= 1'b0;
      pend_adr_q <= 2'd0;
      pend_dat_q <= 32'd0;
      ovr_q      <= 1'b0;
    end else if (sd_we) begin
      pend_v_q   <= 1'b1;
      pend_adr_q <= sd_addr;
      pend_dat_q <= sd_out;
      if (pend_v_q && !consume) ovr_q <= 1'b1;
    end else if (consume) begin
      pend_v_q <= 1'b0;
    end
  end

  // bus FSM: issue writes, poll reads, abort on error or timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 32'd0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      sd_in_q <= 32'd0;
      err_q   <= 1'b0;
      gap_q   <= 8'd0;
      to_q    <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pend_v_q) begin
            state_q <= WR;
            cyc_q   <= 1'b1;
            we_q    <= 1'b1;
            sel_q   <= 4'hF;
            adr_q   <= BASE_ADR + {28'd0, pend_adr_q, 2'b00};
            dat_q   <= pend_dat_q;
            to_q    <= 8'd0;
          end else if (gap_q == 8'd0) begin
            state_q <= RD;
            cyc_q   <= 1'b1;
            we_q    <= 1'b0;
            sel_q   <= 4'hF;
            adr_q   <= BASE_ADR + {28'd0, sd_addr, 2'b00};
            to_q    <= 8'd0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        WR, RD: begin
          if (wb_err_i || wb_ack_i || to_d == TMO) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= 4'd0;
            if (wb_err_i || !wb_ack_i) begin
              err_q <= 1'b1;
            end else if (state_q == RD) begin
              sd_in_q <= wb_dat_i;
            end
            if (state_q == RD) begin
              state_q <= GAP;
              gap_q   <= GAPV;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            to_q <= to_d;
          end
        end
        GAP: begin
          if (pend_v_q) begin
            state_q <= IDLE;
          end else if (gap_q <= 8'd1) begin
            gap_q   <= 8'd0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_wb_bridge.sv
// tb_sd_wb_bridge: directed vectors against a scripted Wishbone slave.
// Expected values are hand-computed constants.
module tb_sd_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sd_addr;
  logic        sd_we;
  logic [31:0] sd_out;
  logic [31:0] sd_in;
  logic        busy, err, ovr;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] rdat = 32'd0;
  logic        ack = 1'b0;
  logic        werr = 1'b0;

  int          ack_delay;
  bit          no_ack;
  bit          err_mode;
  logic [31:0] rdata;
  int          wcnt = 0;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sd_wb_bridge #(
    .BASE_ADR(32'h4000_0000),
    .TIMEOUT (8),
    .POLL_GAP(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sd_addr (sd_addr),
    .sd_we   (sd_we),
    .sd_out  (sd_out),
    .sd_in   (sd_in),
    .busy    (busy),
    .err     (err),
    .ovr     (ovr),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_we_o (wb_we_o),
    .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(rdat),
    .wb_ack_i(ack),
    .wb_err_i(werr)
  );

  // scripted slave: terminates ack_delay cycles after it first sees stb
  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !ack && !werr) begin
      if (wcnt == ack_delay) begin
        ack  <= !no_ack;
        werr <= err_mode;
        rdat <= rdata;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack  <= 1'b0;
      werr <= 1'b0;
      wcnt <= 0;
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          wr_cnt = 0;
  logic [31:0] wr_adr, wr_dat;
  logic [3:0]  wr_sel;
  always @(posedge clk) begin
    if (!reset && wb_cyc_o && wb_we_o && ack && !werr) begin
      wr_cnt = wr_cnt + 1;
      wr_adr = wb_adr_o;
      wr_dat = wb_dat_o;
      wr_sel = wb_sel_o;
    end
  end

  int          rd_st[$];
  logic [31:0] rd_ad[$];
  int          wr_starts = 0;
  int          wr_start = 0;
  logic [31:0] wr_sdin;
  int          rd_end = 0;
  int          n_ends = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          stb_bad = 0;
  int          sel_bad = 0;
  logic        prev_cyc = 1'b0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (wb_stb_o !== wb_cyc_o) stb_bad++;
    if (wb_sel_o !== (wb_cyc_o ? 4'hF : 4'h0)) sel_bad++;
    if (wb_cyc_o && !prev_cyc) begin
      cur_len = 0;
      if (wb_we_o) begin
        wr_starts++;
        wr_start = cyc_n;
        wr_sdin  = sd_in;
      end else begin
        rd_st.push_back(cyc_n);
        rd_ad.push_back(wb_adr_o);
      end
    end
    if (wb_cyc_o) cur_len++;
    if (!wb_cyc_o && prev_cyc) begin
      last_len = cur_len;
      n_ends++;
      if (!prev_we) rd_end = cyc_n;
    end
    prev_cyc = wb_cyc_o;
    prev_we  = wb_we_o;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return rd_st.size();
      1:       return n_ends;
      2:       return wr_cnt;
      default: return wr_starts;
    endcase
  endfunction

  // bounded wait until a monitor counter has grown by n
  task automatic wait_cnt(input int sel, input int n, input int lim,
                          input string tag);
    int base;
    base = cnt_of(sel);
    for (int k = 0; k < lim; k++) begin
      @(posedge clk);
      if (cnt_of(sel) >= base + n) break;
    end
    chk(tag, 32'(cnt_of(sel) >= base + n), 32'd1);
  endtask

  int r0;
  int w0;

  initial begin
    reset     = 1'b1;
    sd_we     = 1'b0;
    sd_addr   = 2'd2;
    sd_out    = 32'd0;
    ack_delay = 0;
    no_ack    = 1'b0;
    err_mode  = 1'b0;
    rdata     = 32'hDEAD_BEEF;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_sdin", sd_in, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rd_st.delete();
    rd_ad.delete();
    r0    = cyc_n;
    reset = 1'b0;

    // periodic polling of register 2
    repeat (24) @(posedge clk);
    chk("npoll", 32'(rd_st.size() >= 3), 32'd1);
    if (rd_st.size() >= 3) begin
      chk("poll0", 32'(rd_st[0]), 32'(r0 + 1));
      chk("per1", 32'(rd_st[1] - rd_st[0]), 32'd7);
      chk("per2", 32'(rd_st[2] - rd_st[1]), 32'd7);
      chk("radr", rd_ad[0], 32'h4000_0008);
    end
    chk("rlen", 32'(last_len), 32'd2);
    @(negedge clk);
    chk("sdin1", sd_in, 32'hDEAD_BEEF);

    // write strobe during an in-flight read
    rdata     = 32'hCAFE_0001;
    ack_delay = 3;
    wait_cnt(0, 1, 40, "t2_rdgo");
    @(negedge clk);
    sd_we   = 1'b1;
    sd_addr = 2'd1;
    sd_out  = 32'h1234_5678;
    @(negedge clk);
    sd_we   = 1'b0;
    sd_addr = 2'd2;
    wait_cnt(2, 1, 40, "t2_wrdone");
    chk("t2_adr", wr_adr, 32'h4000_0004);
    chk("t2_dat", wr_dat, 32'h1234_5678);
    chk("t2_sel", 32'(wr_sel), 32'hF);
    chk("t2_sdin", wr_sdin, 32'hCAFE_0001);
    chk("t2_order", 32'(wr_start > rd_end), 32'd1);
    chk("t2_radr", rd_ad[rd_ad.size() - 1], 32'h4000_0008);
    @(negedge clk);
    chk("t2_ovr", 32'(ovr), 32'd0);

    // two strobes during one stalled read: only the second is written
    ack_delay = 5;
    wait_cnt(0, 1, 40, "t3_rdgo");
    @(negedge clk);
    sd_we   = 1'b1;
    sd_addr = 2'd3;
    sd_out  = 32'hAAAA_0001;
    @(negedge clk);
    sd_out  = 32'hBBBB_0002;
    @(negedge clk);
    sd_we   = 1'b0;
    sd_addr = 2'd2;
    w0 = wr_cnt;
    wait_cnt(2, 1, 40, "t3_wrdone");
    repeat (20) @(posedge clk);
    chk("t3_nwr", 32'(wr_cnt - w0), 32'd1);
    chk("t3_dat", wr_dat, 32'hBBBB_0002);
    chk("t3_adr", wr_adr, 32'h4000_000C);
    @(negedge clk);
    chk("t3_ovr", 32'(ovr), 32'd1);

    // slave never acks: abort after TIMEOUT wait cycles
    chk("t4_err0", 32'(err), 32'd0);
    no_ack = 1'b1;
    wait_cnt(0, 1, 40, "t4_rdgo");
    wait_cnt(1, 1, 40, "t4_abort");
    chk("t4_len", 32'(last_len), 32'd8);
    @(negedge clk);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_sdin", sd_in, 32'hCAFE_0001);
    no_ack = 1'b0;
    rdata  = 32'h5555_AAAA;
    wait_cnt(1, 2, 60, "t4_resume");
    @(negedge clk);
    chk("t4_sdin2", sd_in, 32'h5555_AAAA);

    // reset in the middle of a write cycle
    @(negedge clk);
    sd_we   = 1'b1;
    sd_addr = 2'd0;
    sd_out  = 32'h0BAD_F00D;
    @(negedge clk);
    sd_we   = 1'b0;
    sd_addr = 2'd2;
    w0 = wr_cnt;
    wait_cnt(3, 1, 40, "t6_wrgo");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_cyc", 32'(wb_cyc_o), 32'd0);
    chk("t6_stb", 32'(wb_stb_o), 32'd0);
    chk("t6_we", 32'(wb_we_o), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_ovr", 32'(ovr), 32'd0);
    chk("t6_sdin", sd_in, 32'd0);
    chk("t6_nowr", 32'(wr_cnt - w0), 32'd0);
    reset = 1'b0;

    // ack together with err on a read: data discarded, err set
    ack_delay = 0;
    rdata     = 32'h1111_2222;
    wait_cnt(1, 2, 60, "t5_rd");
    @(negedge clk);
    chk("t5_sdin", sd_in, 32'h1111_2222);
    chk("t5_err0", 32'(err), 32'd0);
    err_mode = 1'b1;
    rdata    = 32'hFFFF_0000;
    wait_cnt(1, 2, 60, "t5_rderr");
    @(negedge clk);
    chk("t5_keep", sd_in, 32'h1111_2222);
    chk("t5_err", 32'(err), 32'd1);
    err_mode = 1'b0;

    chk("stb_eq_cyc", 32'(stb_bad), 32'd0);
    chk("sel_rule", 32'(sel_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
